// File: rtl/mem_arb_pkg.sv
// Shared types for the memory response arbiter: FSM states, grant owner
// and latched operation kind.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INST,
        DATA,
        DONE_I,
        DONE_D
    } state_t;

    typedef enum logic {
        GRANT_INST,
        GRANT_DATA
    } grant_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/mem_resp_arbiter.sv
// Serialises held-level instruction and data requests onto one memory port
// and returns one registered completion pulse per served request.
//
// Handshake: a requester raises *_read / *_write and holds it (with stable
// address) until it sees *_resp high for one cycle; the pmem side holds
// pmem_read / pmem_write until pmem_resp is seen, and pmem_rdata is valid
// only in the pmem_resp cycle. Requests are only sampled in IDLE.
module mem_resp_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_read,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_resp,

    input  logic                data_read,
    input  logic                data_write,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_mbe,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_resp,

    output logic                pmem_read,
    output logic                pmem_write,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [DATA_W-1:0]   pmem_wdata,
    output logic [DATA_W/8-1:0] pmem_mbe,
    input  logic [DATA_W-1:0]   pmem_rdata,
    input  logic                pmem_resp,

    output state_t              dbg_state
);

    state_t                state;
    grant_t                last_grant;
    op_t                   op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   mbe_q;

    logic                  data_req;
    logic                  grant_valid;
    grant_t                grant_sel;

    // Round-robin picker: on contention, the port that was not served last wins.
    always_comb begin
        data_req    = data_read | data_write;
        grant_valid = 1'b0;
        grant_sel   = GRANT_INST;
        if (inst_read && data_req) begin
            grant_valid = 1'b1;
            if (last_grant == GRANT_DATA) begin
                grant_sel = GRANT_INST;
            end else begin
                grant_sel = GRANT_DATA;
            end
        end else if (inst_read) begin
            grant_valid = 1'b1;
            grant_sel   = GRANT_INST;
        end else if (data_req) begin
            grant_valid = 1'b1;
            grant_sel   = GRANT_DATA;
        end
    end

    // Transaction FSM: latch the winner in IDLE, wait for pmem, then pulse resp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_DATA;
            op_q       <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            mbe_q      <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            inst_resp  <= 1'b0;
            data_resp  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        if (grant_sel == GRANT_INST) begin
                            addr_q  <= inst_addr;
                            op_q    <= OP_READ;
                            wdata_q <= '0;
                            mbe_q   <= '0;
                            state   <= INST;
                        end else begin
                            // Write wins over an illegal simultaneous read.
                            addr_q  <= data_addr;
                            op_q    <= data_write ? OP_WRITE : OP_READ;
                            wdata_q <= data_wdata;
                            mbe_q   <= data_mbe;
                            state   <= DATA;
                        end
                    end
                end
                INST: begin
                    if (pmem_resp) begin
                        inst_rdata <= pmem_rdata;
                        inst_resp  <= 1'b1;
                        last_grant <= GRANT_INST;
                        state      <= DONE_I;
                    end
                end
                DATA: begin
                    if (pmem_resp) begin
                        if (op_q == OP_READ) begin
                            data_rdata <= pmem_rdata;
                        end
                        data_resp  <= 1'b1;
                        last_grant <= GRANT_DATA;
                        state      <= DONE_D;
                    end
                end
                DONE_I: begin
                    inst_resp <= 1'b0;
                    state     <= IDLE;
                end
                DONE_D: begin
                    data_resp <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    inst_resp <= 1'b0;
                    data_resp <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes follow the state directly so an async reset drops them at once.
    assign pmem_read    = (state == INST) || ((state == DATA) && (op_q == OP_READ));
    assign pmem_write   = (state == DATA) && (op_q == OP_WRITE);
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign pmem_mbe     = mbe_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_mem_resp_arbiter.sv
// Directed bench for mem_resp_arbiter: a vector table of single transactions
// followed by hand-written sequences for arbitration, held requests and reset.
module tb_mem_resp_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_resp;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_mbe;
    logic [31:0] data_rdata;
    logic        data_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_mbe;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;
    state_t      dbg_state;

    int checks;
    int errors;
    int inst_resp_cnt;
    int data_resp_cnt;
    int pmem_txn_cnt;
    logic strobe_prev;

    mem_resp_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_read    (inst_read),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_resp    (inst_resp),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_mbe     (data_mbe),
        .data_rdata   (data_rdata),
        .data_resp    (data_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_mbe     (pmem_mbe),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Pulse and transaction counters, plus the mutual-exclusion check on resp.
    always @(negedge clk) begin
        if (inst_resp) inst_resp_cnt++;
        if (data_resp) data_resp_cnt++;
        if ((pmem_read | pmem_write) && !strobe_prev) pmem_txn_cnt++;
        strobe_prev = pmem_read | pmem_write;
        if (!rst) begin
            checks++;
            if (inst_resp && data_resp) begin
                errors++;
                $display("FAIL resp_exclusive: inst_resp=1 data_resp=1 required not both");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        inst_read  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        pmem_resp  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk1({tag, "_pmem_read"}, pmem_read, 1'b0);
        chk1({tag, "_pmem_write"}, pmem_write, 1'b0);
        chk1({tag, "_inst_resp"}, inst_resp, 1'b0);
        chk1({tag, "_data_resp"}, data_resp, 1'b0);
    endtask

    // Hold pmem_resp off for k-1 cycles, then complete with rdata.
    task automatic serve(input int k, input logic [31:0] rd);
        for (int i = 1; i < k; i++) tick();
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0;
    endtask

    typedef struct {
        string       name;
        logic        ir;
        logic        dr;
        logic        dw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        logic [31:0] mem_rdata;
        int          wait_cyc;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_inst_rdata;
        logic [31:0] exp_data_rdata;
    } vec_t;

    vec_t vecs[5];

    // One single-requester transaction from IDLE back to IDLE.
    task automatic run_vec(input vec_t v);
        inst_read  = v.ir;
        data_read  = v.dr;
        data_write = v.dw;
        inst_addr  = v.addr;
        data_addr  = v.addr;
        data_wdata = v.wdata;
        data_mbe   = v.mbe;
        tick();
        chk1({v.name, "_pmem_read"}, pmem_read, v.exp_rd);
        chk1({v.name, "_pmem_write"}, pmem_write, v.exp_wr);
        chk32({v.name, "_pmem_addr"}, pmem_address, v.addr);
        if (v.exp_wr) begin
            chk32({v.name, "_pmem_wdata"}, pmem_wdata, v.wdata);
            chk32({v.name, "_pmem_mbe"}, {28'h0, pmem_mbe}, {28'h0, v.mbe});
        end
        // Scramble the request-side fields; the latched values must persist.
        inst_addr  = ~v.addr;
        data_addr  = ~v.addr;
        data_wdata = ~v.wdata;
        data_mbe   = ~v.mbe;
        for (int i = 1; i < v.wait_cyc; i++) begin
            tick();
            chk1({v.name, "_hold_read"}, pmem_read, v.exp_rd);
            chk1({v.name, "_hold_write"}, pmem_write, v.exp_wr);
            chk32({v.name, "_hold_addr"}, pmem_address, v.addr);
            if (v.exp_wr) chk32({v.name, "_hold_wdata"}, pmem_wdata, v.wdata);
            chk1({v.name, "_early_resp"}, inst_resp | data_resp, 1'b0);
        end
        serve(1, v.mem_rdata);
        chk1({v.name, "_inst_resp"}, inst_resp, v.ir);
        chk1({v.name, "_data_resp"}, data_resp, ~v.ir);
        chk32({v.name, "_inst_rdata"}, inst_rdata, v.exp_inst_rdata);
        chk32({v.name, "_data_rdata"}, data_rdata, v.exp_data_rdata);
        chk1({v.name, "_done_strobe"}, pmem_read | pmem_write, 1'b0);
        inst_read  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        tick();
        check_idle_outputs({v.name, "_after"});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        inst_resp_cnt = 0;
        data_resp_cnt = 0;
        pmem_txn_cnt  = 0;
        strobe_prev   = 1'b0;
        inst_addr     = 32'h0;
        data_addr     = 32'h0;
        data_wdata    = 32'h0;
        data_mbe      = 4'h0;
        pmem_rdata    = 32'h0;

        vecs[0] = '{"inst_rd", 1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0, 4'h0,
                    32'h00A0_0093, 3, 1'b1, 1'b0, 32'h00A0_0093, 32'h0};
        vecs[1] = '{"data_wr", 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011,
                    32'h5555_5555, 2, 1'b0, 1'b1, 32'h00A0_0093, 32'h0};
        vecs[2] = '{"data_rd", 1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0,
                    32'h1234_5678, 1, 1'b1, 1'b0, 32'h00A0_0093, 32'h1234_5678};
        vecs[3] = '{"rd_and_wr", 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF,
                    32'h9999_9999, 2, 1'b0, 1'b1, 32'h00A0_0093, 32'h1234_5678};
        vecs[4] = '{"inst_rd2", 1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'h0, 4'h0,
                    32'h0010_8093, 2, 1'b1, 1'b0, 32'h0010_8093, 32'h1234_5678};

        // Reset state
        do_reset();
        check_idle_outputs("reset");
        chk32("reset_addr", pmem_address, 32'h0);
        chk32("reset_inst_rdata", inst_rdata, 32'h0);
        chk32("reset_data_rdata", data_rdata, 32'h0);
        chk32("reset_state", {29'h0, dbg_state}, {29'h0, IDLE});

        // pmem_resp while idle is ignored
        pmem_resp  = 1'b1;
        pmem_rdata = 32'hFFFF_FFFF;
        tick();
        pmem_resp  = 1'b0;
        tick();
        check_idle_outputs("stray_resp");
        chk32("stray_resp_data_rdata", data_rdata, 32'h0);

        // Vector table
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Contention after reset: inst first, then data; inst held through
        // its DONE cycle then competes again and loses to data.
        do_reset();
        inst_read = 1'b1;
        inst_addr = 32'h0000_0080;
        data_read = 1'b1;
        data_addr = 32'h0000_0100;
        tick();
        chk1("rr1_inst_read", pmem_read, 1'b1);
        chk32("rr1_inst_addr", pmem_address, 32'h0000_0080);
        serve(1, 32'hAAAA_0001);
        chk1("rr1_inst_resp", inst_resp, 1'b1);
        chk1("rr1_no_data_resp", data_resp, 1'b0);
        chk32("rr1_inst_rdata", inst_rdata, 32'hAAAA_0001);
        inst_addr = 32'h0000_0084;
        tick();
        check_idle_outputs("rr1_gap");
        tick();
        chk1("rr2_data_read", pmem_read, 1'b1);
        chk32("rr2_data_addr", pmem_address, 32'h0000_0100);
        serve(2, 32'hBBBB_0002);
        chk1("rr2_data_resp", data_resp, 1'b1);
        chk1("rr2_no_inst_resp", inst_resp, 1'b0);
        chk32("rr2_data_rdata", data_rdata, 32'hBBBB_0002);
        chk32("rr2_inst_rdata_held", inst_rdata, 32'hAAAA_0001);
        data_read = 1'b0;
        tick();
        check_idle_outputs("rr2_gap");
        tick();
        chk1("rr3_inst_read", pmem_read, 1'b1);
        chk32("rr3_inst_addr", pmem_address, 32'h0000_0084);
        serve(1, 32'hCCCC_0003);
        chk1("rr3_inst_resp", inst_resp, 1'b1);
        chk32("rr3_inst_rdata", inst_rdata, 32'hCCCC_0003);
        inst_read = 1'b0;
        tick();
        check_idle_outputs("rr3_after");

        // Data read held through its response cycle is served exactly once.
        data_resp_cnt = 0;
        pmem_txn_cnt  = 0;
        data_read = 1'b1;
        data_addr = 32'h0000_0500;
        tick();
        chk1("held_pmem_read", pmem_read, 1'b1);
        serve(1, 32'h0BAD_F00D);
        chk1("held_data_resp", data_resp, 1'b1);
        tick();
        data_read = 1'b0;
        chk1("held_idle_resp", data_resp, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("held_no_restrobe", pmem_read, 1'b0);
        end
        chk_int("held_resp_count", data_resp_cnt, 1);
        chk_int("held_txn_count", pmem_txn_cnt, 1);
        chk32("held_data_rdata", data_rdata, 32'h0BAD_F00D);

        // Async reset in the middle of a data read.
        data_resp_cnt = 0;
        data_read = 1'b1;
        data_addr = 32'h0000_0400;
        tick();
        chk1("rstmid_pmem_read", pmem_read, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("rstmid_read_drop", pmem_read, 1'b0);
        chk32("rstmid_state", {29'h0, dbg_state}, {29'h0, IDLE});
        data_read  = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h7777_7777;
        tick();
        pmem_resp  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk_int("rstmid_no_data_resp", data_resp_cnt, 0);
        chk32("rstmid_data_rdata", data_rdata, 32'h0);
        inst_read = 1'b1;
        inst_addr = 32'h0000_0090;
        tick();
        chk1("rstpost_inst_read", pmem_read, 1'b1);
        chk32("rstpost_inst_addr", pmem_address, 32'h0000_0090);
        serve(2, 32'h0000_0013);
        chk1("rstpost_inst_resp", inst_resp, 1'b1);
        chk32("rstpost_inst_rdata", inst_rdata, 32'h0000_0013);
        inst_read = 1'b0;
        tick();
        check_idle_outputs("rstpost_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
